// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with word-per-beat line refill
module icache_dm #(
  parameter int          NUM_LINES      = 16,
  parameter int          WORDS_PER_LINE = 4,
  parameter logic [31:0] NOP            = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_ready,
  input  logic [31:0] addr,
  output logic        cache_ack,
  output logic [31:0] inst,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int WORDS   = NUM_LINES * WORDS_PER_LINE;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REFILL  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  // Cache storage; only the valid bits carry reset state
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [31:0]          r_data [WORDS];

  // Control state and registered outputs
  state_t               r_state;
  logic [TAG_W-1:0]     r_req_tag;
  logic [IDX_W-1:0]     r_req_idx;
  logic [OFF_W-1:0]     r_req_off;
  logic [OFF_W-1:0]     r_beat;
  logic                 r_flush_seen;
  logic                 r_ack;
  logic [31:0]          r_inst;
  logic                 r_mem_req;
  logic [31:0]          r_mem_addr;

  // Lookup fields of the incoming fetch address
  logic [TAG_W-1:0]     w_in_tag;
  logic [IDX_W-1:0]     w_in_idx;
  logic [OFF_W-1:0]     w_in_off;
  logic                 w_hit;
  logic [31:0]          w_hit_word;

  // Refill datapath
  logic                 w_fill_we;
  logic                 w_last_beat;
  logic [OFF_W-1:0]     w_next_beat;
  logic [31:0]          w_fill_word;
  logic                 w_unused_addr;

  assign w_in_tag   = addr[31:TAG_LSB];
  assign w_in_idx   = addr[TAG_LSB-1:OFF_W+2];
  assign w_in_off   = addr[OFF_W+1:2];

  // Byte-lane bits of the fetch address play no part in the lookup
  assign w_unused_addr = &{1'b0, addr[1:0]};

  // Lookup uses the valid bits as they stand before any same-cycle flush
  assign w_hit      = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
  assign w_hit_word = r_data[{w_in_idx, w_in_off}];

  assign w_fill_we   = (r_state == S_REFILL) && mem_ack && !rst;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_next_beat = r_beat + OFF_W'(1);

  // The requested word either arrived in an earlier beat or is on mem_rdata right now
  assign w_fill_word = (r_req_off == r_beat) ? mem_rdata : r_data[{r_req_idx, r_req_off}];

  assign cache_ack = r_ack;
  assign inst      = r_inst;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;

  // Data and tag arrays: written only by refill beats, never reset
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[{r_req_idx, r_beat}] <= mem_rdata;
      if (w_last_beat) begin
        r_tag[r_req_idx] <= r_req_tag;
      end
    end
  end

  // Control FSM with registered ack/inst/memory-request outputs and valid-bit upkeep
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
      r_req_off    <= '0;
      r_beat       <= '0;
      r_flush_seen <= 1'b0;
      r_ack        <= 1'b0;
      r_inst       <= NOP;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (addr_ready) begin
            r_req_tag <= w_in_tag;
            r_req_idx <= w_in_idx;
            r_req_off <= w_in_off;
            if (w_hit) begin
              r_ack  <= 1'b1;
              r_inst <= w_hit_word;
            end else begin
              r_state      <= S_REFILL;
              r_mem_req    <= 1'b1;
              r_mem_addr   <= {w_in_tag, w_in_idx, {OFF_W{1'b0}}, 2'b00};
              r_beat       <= '0;
              r_flush_seen <= 1'b0;
            end
          end
        end
        S_REFILL: begin
          if (flush) begin
            r_flush_seen <= 1'b1;
          end
          if (mem_ack) begin
            r_beat     <= w_next_beat;
            r_mem_addr <= {r_req_tag, r_req_idx, w_next_beat, 2'b00};
            if (w_last_beat) begin
              r_mem_req          <= 1'b0;
              r_ack              <= 1'b1;
              r_inst             <= w_fill_word;
              r_state            <= S_RESPOND;
              r_valid[r_req_idx] <= !(r_flush_seen || flush);
            end
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // A flush wipes every line, overriding a valid set in the same cycle
      if (flush) begin
        r_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - randomized self-checking bench for icache_dm against a line-level cache model
module tb_icache_dm;

  localparam int          NL  = 16;
  localparam int          WPL = 4;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] LINE_BYTES = 32'(4 * WPL);

  logic        clk;
  logic        rst;
  logic        addr_ready;
  logic [31:0] addr;
  logic        cache_ack;
  logic [31:0] inst;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: which memory line each cache slot holds, and the last returned word
  bit          m_valid [NL];
  logic [31:0] m_line  [NL];
  logic [31:0] m_inst;

  icache_dm #(
    .NUM_LINES      (NL),
    .WORDS_PER_LINE (WPL),
    .NOP            (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_ready (addr_ready),
    .addr       (addr),
    .cache_ack  (cache_ack),
    .inst       (inst),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a;
    if ((w / LINE_BYTES) == 32'd0) return 32'hA0 + {30'd0, w[3:2]};
    return (w * 32'h9E3779B1) ^ 32'h5EED0000;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a / LINE_BYTES;
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    return int'(line_of(a) % 32'(NL));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[slot_of(a)] && (m_line[slot_of(a)] == line_of(a));
  endfunction

  task automatic model_flush();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_flush();
    check("flush_noack", cache_ack, 1'b0);
  endtask

  task automatic idle_cycle();
    step();
    check("idle_noack", cache_ack, 1'b0);
    check("idle_inst_hold", inst, m_inst);
    check("idle_noreq", mem_req, 1'b0);
  endtask

  // One fetch; on a miss the bench plays memory with a fixed per-beat latency
  task automatic do_fetch(input logic [31:0] a, input int lat, input bit busy,
                          input bit flush_ref, input bit flush_acc, input bit poke_resp);
    logic [31:0] base;
    logic [31:0] exp_word;
    bit          hit;
    bit          fl_seen;
    int          busy_beat;
    int          flush_beat;
    hit        = model_hit(a);
    exp_word   = mem_word({a[31:2], 2'b00});
    base       = line_of(a) * LINE_BYTES;
    fl_seen    = 1'b0;
    busy_beat  = $urandom_range(0, WPL - 1);
    flush_beat = $urandom_range(0, WPL - 1);
    addr_ready = 1'b1;
    addr       = a;
    flush      = flush_acc;
    step();
    addr_ready = 1'b0;
    flush      = 1'b0;
    if (flush_acc) model_flush();
    if (hit) begin
      check("hit_ack", cache_ack, 1'b1);
      check("hit_inst", inst, exp_word);
      check("hit_noreq", mem_req, 1'b0);
      m_inst = exp_word;
      return;
    end
    check("miss_noack", cache_ack, 1'b0);
    for (int b = 0; b < WPL; b++) begin
      for (int w = 0; w < lat; w++) begin
        check("refill_req", mem_req, 1'b1);
        check("refill_addr", mem_addr, base + 32'(4 * b));
        check("refill_noack", cache_ack, 1'b0);
        check("refill_inst_hold", inst, m_inst);
        step();
      end
      check("beat_req", mem_req, 1'b1);
      check("beat_addr", mem_addr, base + 32'(4 * b));
      check("beat_noack", cache_ack, 1'b0);
      mem_ack   = 1'b1;
      mem_rdata = mem_word(base + 32'(4 * b));
      if (flush_ref && b == flush_beat) begin
        flush   = 1'b1;
        fl_seen = 1'b1;
      end
      if (busy && b == busy_beat) begin
        addr_ready = 1'b1;
        addr       = 32'h00000200 ^ ($urandom & 32'h0000FFFC);
      end
      step();
      mem_ack    = 1'b0;
      mem_rdata  = 32'hBAD0BAD0;
      flush      = 1'b0;
      addr_ready = 1'b0;
    end
    check("resp_ack", cache_ack, 1'b1);
    check("resp_inst", inst, exp_word);
    check("resp_noreq", mem_req, 1'b0);
    m_inst = exp_word;
    if (fl_seen) model_flush();
    m_line[slot_of(a)]  = line_of(a);
    m_valid[slot_of(a)] = !fl_seen;
    if (poke_resp) begin
      addr_ready = 1'b1;
      addr       = a;
    end
    step();
    addr_ready = 1'b0;
    check("after_resp_noack", cache_ack, 1'b0);
    check("after_resp_noreq", mem_req, 1'b0);
    check("after_resp_inst_hold", inst, m_inst);
  endtask

  // Reset arrives while the third beat is outstanding; a late beat ack must be ignored
  task automatic do_reset_mid(input logic [31:0] a);
    logic [31:0] base;
    base       = line_of(a) * LINE_BYTES;
    addr_ready = 1'b1;
    addr       = a;
    step();
    addr_ready = 1'b0;
    check("rm_req", mem_req, 1'b1);
    for (int b = 0; b < 2; b++) begin
      check("rm_beat_addr", mem_addr, base + 32'(4 * b));
      mem_ack   = 1'b1;
      mem_rdata = mem_word(base + 32'(4 * b));
      step();
      mem_ack = 1'b0;
    end
    check("rm_beat2_addr", mem_addr, base + 32'd8);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_flush();
    m_inst = NOP;
    check("rm_noreq", mem_req, 1'b0);
    check("rm_noack", cache_ack, 1'b0);
    check("rm_inst_nop", inst, NOP);
    check("rm_addr_zero", mem_addr, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 1'b0;
    check("stale_noack", cache_ack, 1'b0);
    check("stale_noreq", mem_req, 1'b0);
    check("stale_inst", inst, NOP);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 4) == 0) begin
      a = 32'hFFFFFF00 | (32'($urandom_range(0, 63)) << 2);
    end else begin
      a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, NL - 1)) << 4)
        | (32'($urandom_range(0, WPL - 1)) << 2) | 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  initial begin
    logic [31:0] a;
    rst        = 1'b1;
    addr_ready = 1'b0;
    addr       = '0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    model_flush();
    for (int i = 0; i < NL; i++) m_line[i] = '0;
    m_inst = NOP;
    step();
    step();
    rst = 1'b0;
    check("reset_ack", cache_ack, 1'b0);
    check("reset_inst", inst, NOP);
    check("reset_req", mem_req, 1'b0);
    check("reset_addr", mem_addr, 32'd0);

    do_fetch(32'h00000008, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h0000000C, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h00000100, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h00000008, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h00000300, 2, 1'b1, 1'b0, 1'b0, 1'b1);
    do_fetch(32'h00000000, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_flush();
    do_fetch(32'h00000000, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h00000004, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    do_fetch(32'h00000004, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'h00000044, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    do_fetch(32'h00000044, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'hFFFFFFFC, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_fetch(32'hFFFFFFF0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_flush();
    do_reset_mid(32'h00000080);
    do_fetch(32'h00000088, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      a = rand_addr();
      do_fetch(a, $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0),
               model_hit(a) && ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 19) == 0) do_flush();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
